wb_intercon_n: RTL

WB_INTERCON_N -- requirements
Module: wb_intercon_n

---
 rtl/wb_intercon_n.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/wb_intercon_n.sv
// wb_intercon_n: single-master Wishbone interconnect fanning out to NSLAVE slaves by base/mask decode.
// Optional ACTIVE watchdog: define WB_INTERCON_TIMEOUT_EN to abort unacknowledged transfers after TIMEOUT cycles.
module wb_intercon_n #(
    parameter int                             DATA_WIDTH = 16,
    parameter int                             ADDR_WIDTH = 16,
    parameter int                             NSLAVE     = 4,
    parameter logic [NSLAVE*ADDR_WIDTH-1:0]   SLAVE_BASE = {16'h0130, 16'h0120, 16'h0100, 16'h0000},
    parameter logic [NSLAVE*ADDR_WIDTH-1:0]   SLAVE_MASK = {16'hFFF0, 16'hFFF0, 16'hFFF0, 16'hFF00},
    parameter int                             TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          m_cyc,
    input  logic                          m_stb,
    input  logic                          m_we,
    input  logic [ADDR_WIDTH-1:0]         m_addr,
    input  logic [DATA_WIDTH-1:0]         m_wrdata,
    output logic [DATA_WIDTH-1:0]         m_rddata,
    output logic                          m_ack,
    output logic                          m_err,
    output logic [NSLAVE-1:0]             s_cyc,
    output logic [NSLAVE-1:0]             s_stb,
    output logic [NSLAVE-1:0]             s_we,
    output logic [NSLAVE*ADDR_WIDTH-1:0]  s_addr,
    output logic [NSLAVE*DATA_WIDTH-1:0]  s_wrdata,
    input  logic [NSLAVE*DATA_WIDTH-1:0]  s_rddata,
    input  logic [NSLAVE-1:0]             s_ack
);

    if (NSLAVE < 1 || NSLAVE > 16 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("wb_intercon_n: NSLAVE must be 1..16 and TIMEOUT 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [NSLAVE-1:0]       sel_q, sel_d;
    logic [NSLAVE-1:0]       hit_onehot;
    logic                    live;
    logic                    sel_ack;
    logic [DATA_WIDTH-1:0]   sel_rddata;

`ifdef WB_INTERCON_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0] cnt_q, cnt_d;
`endif

    // Descending scan so the lowest matching index is the last one written and wins.
    always_comb begin : decode
        hit_onehot = '0;
        for (int i = NSLAVE - 1; i >= 0; i--) begin
            if ((m_addr & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    // A reset cycle already silences the fabric, so an ack arriving alongside rst is never forwarded.
    assign live = (state_q == ST_ACTIVE) && !rst;

    always_comb begin : sel_mux
        sel_ack    = 1'b0;
        sel_rddata = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (sel_q[i]) begin
                sel_ack    = sel_ack | s_ack[i];
                sel_rddata = sel_rddata | s_rddata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin : slave_drive
        s_cyc    = '0;
        s_stb    = '0;
        s_we     = '0;
        s_addr   = '0;
        s_wrdata = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (live && sel_q[i]) begin
                s_cyc[i]                              = m_cyc;
                s_stb[i]                              = m_stb;
                s_we[i]                               = m_we;
                s_addr[i*ADDR_WIDTH +: ADDR_WIDTH]    = m_addr & ~SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
                s_wrdata[i*DATA_WIDTH +: DATA_WIDTH]  = m_wrdata;
            end
        end
    end

    // m_ack lives only in ACTIVE and m_err only in ERROR, so the two can never coincide.
    assign m_ack    = live && m_cyc && sel_ack;
    assign m_err    = (state_q == ST_ERROR) && !rst;
    assign m_rddata = live ? sel_rddata : '0;

    // NOTE: every always_comb output gets a default first; a missing branch would otherwise infer a latch.
    always_comb begin : fsm_next
        state_d = state_q;
        sel_d   = sel_q;
`ifdef WB_INTERCON_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (m_cyc && m_stb) begin
                    if (|hit_onehot) begin
                        state_d = ST_ACTIVE;
                        sel_d   = hit_onehot;
`ifdef WB_INTERCON_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ACTIVE: begin
                if (!m_cyc || sel_ack) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end
`ifdef WB_INTERCON_TIMEOUT_EN
                else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == TIMEOUT_CNT) begin
                        state_d = ST_ERROR;
                        sel_d   = '0;
                    end
                end
`endif
            end
            ST_ERROR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
`ifdef WB_INTERCON_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
`ifdef WB_INTERCON_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule
